axi_lite_regfile_slave: RTL and testbench

AXI4-Lite slave register file that sits directly downstream of axi_interconnect. It terminates one slave port (S_AXI_*) and holds NUM_REGS 32-bit control/status registers. It supports full read and write channels, WSTRB byte enables, and error responses for out-of-window accesses. It exports register contents and per-register write strobes to the surrounding hardware.

---
 rtl/axi_lite_pkg.sv | 30 +++
 rtl/axi_lite_addr_decode.sv | 33 +++
 rtl/axi_lite_regfile_slave.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_axi_lite_regfile_slave.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared AXI4-Lite definitions: response codes (also used by axi_interconnect),
// state encodings for the register-file slave's write and read FSMs, and a
// helper that sizes register index fields.
// No ports (package).
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Width of a register index; never zero so a single-register file still
    // has a legal one-bit index vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// ---------------------------------------------------------------------------
// axi_lite_addr_decode
// Combinational byte-address to register-index decoder for the register file
// slave. The two low address bits are ignored (word-granular registers).
// Ports:
//   addr      in   ADDR_WIDTH  byte address from AW or AR channel
//   idx       out  IDX_W       register index (meaningful only when in_range)
//   in_range  out  1           address falls inside the register window
// ---------------------------------------------------------------------------
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    IDX_W      = idx_width(NUM_REGS)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_W-1:0]      idx,
    output logic                  in_range
);

    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

    logic [ADDR_WIDTH-1:0] off;

    assign off      = addr - BASE_ADDR;
    assign idx      = off[2 +: IDX_W];
    // The lower-bound test catches addresses below the window, whose offset
    // wraps to a large value.
    assign in_range = (addr >= BASE_ADDR) && ((off >> 2) < NUM_REGS_A);

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile_slave
// AXI4-Lite slave holding NUM_REGS 32-bit registers with byte-enable writes,
// exporting register contents and per-register write strobes.
// Build option: AXI_REGFILE_ERR_EN -- when defined, out-of-window accesses
// answer SLVERR; otherwise they answer OKAY (reads return 0, writes dropped).
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN   clock, synchronous active-low reset
//   S_AXI_AW*                    write address channel (AWPROT ignored)
//   S_AXI_W*                     write data channel with byte strobes
//   S_AXI_B*                     write response channel
//   S_AXI_AR*                    read address channel (ARPROT ignored)
//   S_AXI_R*                     read data channel
//   reg_out   out NUM_REGS*32    register i at [32i+31:32i]
//   wr_pulse  out NUM_REGS       one-cycle strobe the cycle after reg i commits
// ---------------------------------------------------------------------------
// Handshake: a transfer happens on a rising edge where VALID and READY are both
// high. A source holds VALID and its payload stable until that edge; all READY
// and VALID outputs here are registered, so nothing is accepted combinationally.
module axi_lite_regfile_slave
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           S_AXI_ACLK,
    input  logic                           S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = idx_width(NUM_REGS);

`ifdef AXI_REGFILE_ERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_pulse_q;

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    w_state_t              w_state, w_state_n;
    logic                  aw_ready_q, aw_ready_n;
    logic                  w_ready_q, w_ready_n;
    logic                  aw_got_q, aw_got_n;
    logic                  w_got_q, w_got_n;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [STRB_W-1:0]     wstrb_q, wstrb_n;
    logic                  bvalid_q, bvalid_n;
    logic [1:0]            bresp_q, bresp_n;

    logic [IDX_W-1:0]      aw_idx;
    logic                  aw_in_range;
    logic                  commit;

    // Decode the latched write address so the commit cycle sees a stable index.
    axi_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_aw_decode (
        .addr     (awaddr_q),
        .idx      (aw_idx),
        .in_range (aw_in_range)
    );

    assign commit = (w_state == W_COMMIT);

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_state    <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            w_state    <= w_state_n;
            aw_ready_q <= aw_ready_n;
            w_ready_q  <= w_ready_n;
            aw_got_q   <= aw_got_n;
            w_got_q    <= w_got_n;
            awaddr_q   <= awaddr_n;
            wdata_q    <= wdata_n;
            wstrb_q    <= wstrb_n;
            bvalid_q   <= bvalid_n;
            bresp_q    <= bresp_n;
        end
    end

    always_comb begin
        w_state_n  = w_state;
        aw_ready_n = aw_ready_q;
        w_ready_n  = w_ready_q;
        aw_got_n   = aw_got_q;
        w_got_n    = w_got_q;
        awaddr_n   = awaddr_q;
        wdata_n    = wdata_q;
        wstrb_n    = wstrb_q;
        bvalid_n   = bvalid_q;
        bresp_n    = bresp_q;
        unique case (w_state)
            W_IDLE: begin
                // AW and W are captured independently; each READY drops once
                // its half is held, and the commit starts when both are held.
                if (aw_ready_q && S_AXI_AWVALID) begin
                    aw_got_n = 1'b1;
                    awaddr_n = S_AXI_AWADDR;
                end
                if (w_ready_q && S_AXI_WVALID) begin
                    w_got_n = 1'b1;
                    wdata_n = S_AXI_WDATA;
                    wstrb_n = S_AXI_WSTRB;
                end
                aw_ready_n = !aw_got_n;
                w_ready_n  = !w_got_n;
                if (aw_got_n && w_got_n) begin
                    w_state_n = W_COMMIT;
                end
            end
            W_COMMIT: begin
                aw_got_n  = 1'b0;
                w_got_n   = 1'b0;
                bvalid_n  = 1'b1;
                bresp_n   = aw_in_range ? RESP_OKAY : OOR_RESP;
                w_state_n = W_RESP;
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_n   = 1'b0;
                    aw_ready_n = 1'b1;
                    w_ready_n  = 1'b1;
                    w_state_n  = W_IDLE;
                end
            end
            default: begin
                w_state_n = W_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register storage and write strobes
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (commit && aw_in_range) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb_q[b]) begin
                        regs[aw_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
                wr_pulse_q[aw_idx] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_t              r_state, r_state_n;
    logic                  ar_ready_q, ar_ready_n;
    logic                  rvalid_q, rvalid_n;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
    logic [1:0]            rresp_q, rresp_n;

    logic [IDX_W-1:0]      ar_idx;
    logic                  ar_in_range;

    axi_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_ar_decode (
        .addr     (S_AXI_ARADDR),
        .idx      (ar_idx),
        .in_range (ar_in_range)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state    <= R_IDLE;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            r_state    <= r_state_n;
            ar_ready_q <= ar_ready_n;
            rvalid_q   <= rvalid_n;
            rdata_q    <= rdata_n;
            rresp_q    <= rresp_n;
        end
    end

    always_comb begin
        r_state_n  = r_state;
        ar_ready_n = ar_ready_q;
        rvalid_n   = rvalid_q;
        rdata_n    = rdata_q;
        rresp_n    = rresp_q;
        unique case (r_state)
            R_IDLE: begin
                ar_ready_n = 1'b1;
                if (ar_ready_q && S_AXI_ARVALID) begin
                    // regs is sampled before any same-edge commit lands, so a
                    // colliding read returns the pre-write value.
                    ar_ready_n = 1'b0;
                    rvalid_n   = 1'b1;
                    rdata_n    = ar_in_range ? regs[ar_idx] : '0;
                    rresp_n    = ar_in_range ? RESP_OKAY : OOR_RESP;
                    r_state_n  = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_n   = 1'b0;
                    ar_ready_n = 1'b1;
                    r_state_n  = R_IDLE;
                end
            end
            default: begin
                r_state_n = R_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = w_ready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign wr_pulse      = wr_pulse_q;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
        assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
    end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
module tb_axi_lite_regfile_slave;

  localparam int NREGS = 8;

`ifdef AXI_REGFILE_ERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [31:0]        s_axi_awaddr;
  logic [2:0]         s_axi_awprot;
  logic               s_axi_awvalid;
  logic               s_axi_awready;
  logic [31:0]        s_axi_wdata;
  logic [3:0]         s_axi_wstrb;
  logic               s_axi_wvalid;
  logic               s_axi_wready;
  logic [1:0]         s_axi_bresp;
  logic               s_axi_bvalid;
  logic               s_axi_bready;
  logic [31:0]        s_axi_araddr;
  logic [2:0]         s_axi_arprot;
  logic               s_axi_arvalid;
  logic               s_axi_arready;
  logic [31:0]        s_axi_rdata;
  logic [1:0]         s_axi_rresp;
  logic               s_axi_rvalid;
  logic               s_axi_rready;
  logic [NREGS*32-1:0] reg_out;
  logic [NREGS-1:0]   wr_pulse;

  axi_lite_regfile_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rstn),
    .S_AXI_AWADDR  (s_axi_awaddr),
    .S_AXI_AWPROT  (s_axi_awprot),
    .S_AXI_AWVALID (s_axi_awvalid),
    .S_AXI_AWREADY (s_axi_awready),
    .S_AXI_WDATA   (s_axi_wdata),
    .S_AXI_WSTRB   (s_axi_wstrb),
    .S_AXI_WVALID  (s_axi_wvalid),
    .S_AXI_WREADY  (s_axi_wready),
    .S_AXI_BRESP   (s_axi_bresp),
    .S_AXI_BVALID  (s_axi_bvalid),
    .S_AXI_BREADY  (s_axi_bready),
    .S_AXI_ARADDR  (s_axi_araddr),
    .S_AXI_ARPROT  (s_axi_arprot),
    .S_AXI_ARVALID (s_axi_arvalid),
    .S_AXI_ARREADY (s_axi_arready),
    .S_AXI_RDATA   (s_axi_rdata),
    .S_AXI_RRESP   (s_axi_rresp),
    .S_AXI_RVALID  (s_axi_rvalid),
    .S_AXI_RREADY  (s_axi_rready),
    .reg_out       (reg_out),
    .wr_pulse      (wr_pulse)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];   // {rresp, rdata}
  logic [31:0] model [NREGS];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected handshake", name);
  endtask

  function automatic logic [NREGS*32-1:0] model_flat();
    logic [NREGS*32-1:0] r;
    for (int i = 0; i < NREGS; i++) r[32*i +: 32] = model[i];
    return r;
  endfunction

  // Response monitor: samples just after the falling edge, when both the
  // registered DUT outputs and the bench-driven READYs are settled.
  always begin
    @(negedge clk);
    #1;
    if (rstn && s_axi_bvalid && s_axi_bready) begin
      if (exp_b_q.size() == 0) fail_now("b_unexpected");
      else check("bresp", {254'd0, s_axi_bresp}, {254'd0, exp_b_q.pop_front()});
    end
    if (rstn && s_axi_rvalid && s_axi_rready) begin
      if (exp_r_q.size() == 0) fail_now("r_unexpected");
      else check("rresp_rdata", {222'd0, s_axi_rresp, s_axi_rdata}, {222'd0, exp_r_q.pop_front()});
    end
  end

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input logic [1:0] exp_resp);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_fire, w_fire;
    exp_b_q.push_back(exp_resp);
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      s_axi_awaddr  = addr;
      s_axi_wdata   = data;
      s_axi_wstrb   = strb;
      s_axi_awvalid = !aw_done && (c >= aw_dly);
      s_axi_wvalid  = !w_done && (c >= w_dly);
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid && s_axi_wready;
      @(negedge clk);
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
    end
    s_axi_awvalid = 0;
    s_axi_wvalid  = 0;
    if (!(aw_done && w_done)) begin
      fail_now("write_accept");
      void'(exp_b_q.pop_back());
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    bit done = 0;
    exp_r_q.push_back({exp_resp, exp_data});
    for (int c = 0; c < 40 && !done; c++) begin
      s_axi_araddr  = addr;
      s_axi_arvalid = 1;
      done = s_axi_arready;
      @(negedge clk);
    end
    s_axi_arvalid = 0;
    if (!done) begin
      fail_now("read_accept");
      void'(exp_r_q.pop_back());
    end else begin
      check("rvalid_latency", {255'd0, s_axi_rvalid}, 256'd1);
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
      fail_now("drain");
      exp_b_q.delete();
      exp_r_q.delete();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    bit          in_range;
    logic [31:0] exp_val;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int idx;
    vecs[0] = '{32'h0000_000C, 32'hA5A5_A5A5, 4'b1111, 0, 0, 1'b1, 32'hA5A5_A5A5, 2'b00};
    vecs[1] = '{32'h0000_000C, 32'h1234_5678, 4'b1000, 1, 0, 1'b1, 32'h12A5_A5A5, 2'b00};
    vecs[2] = '{32'h0000_001C, 32'h8765_4321, 4'b0011, 0, 2, 1'b1, 32'h0000_4321, 2'b00};
    vecs[3] = '{32'h0000_001F, 32'hFFFF_FFFF, 4'b1100, 0, 0, 1'b1, 32'hFFFF_4321, 2'b00};
    vecs[4] = '{32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 0, 0, 1'b1, 32'h0000_0000, 2'b00};
    vecs[5] = '{32'h0000_0020, 32'h5555_AAAA, 4'b1111, 0, 0, 1'b0, 32'h0000_0000, OOR_RESP};
    vecs[6] = '{32'hFFFF_FFFC, 32'h1357_9BDF, 4'b1111, 2, 1, 1'b0, 32'h0000_0000, OOR_RESP};
    for (int i = 0; i < NREGS; i++) model[i] = '0;

    rstn = 0;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 0;
    s_axi_bready = 1; s_axi_rready = 1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", {255'd0, s_axi_awready}, 256'd0);
    check("rst_arready", {255'd0, s_axi_arready}, 256'd0);
    check("rst_valids", {254'd0, s_axi_bvalid, s_axi_rvalid}, 256'd0);
    check("rst_rdata", {224'd0, s_axi_rdata}, 256'd0);
    check("rst_reg_out", {'0, reg_out}, 256'd0);
    rstn = 1;
    @(negedge clk);
    check("idle_readies", {253'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 256'd7);
    check("idle_valids", {254'd0, s_axi_bvalid, s_axi_rvalid}, 256'd0);
    check("idle_wr_pulse", {248'd0, wr_pulse}, 256'd0);

    // AW and W together to reg1
    do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00);
    @(negedge clk);
    model[1] = 32'hDEAD_BEEF;
    check("wr_pulse_reg1", {248'd0, wr_pulse}, 256'h02);
    check("reg_out_reg1", {'0, reg_out}, {'0, model_flat()});
    @(negedge clk);
    check("wr_pulse_clear", {248'd0, wr_pulse}, 256'd0);
    wait_drain();
    do_read(32'h4, 32'hDEAD_BEEF, 2'b00);
    wait_drain();

    // Table-driven writes with read-back
    for (int i = 0; i < 7; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, vecs[i].exp_resp);
      wait_drain();
      if (vecs[i].in_range) begin
        idx = int'(vecs[i].addr[4:2]);
        model[idx] = vecs[i].exp_val;
      end
      check($sformatf("vec%0d_reg_out", i), {'0, reg_out}, {'0, model_flat()});
      do_read(vecs[i].addr, vecs[i].exp_val, vecs[i].exp_resp);
      wait_drain();
    end

    // W three cycles ahead of AW, then BREADY held low
    s_axi_bready = 0;
    do_write(32'h8, 32'h1122_3344, 4'b0101, 3, 0, 2'b00);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bvalid_hold", {255'd0, s_axi_bvalid}, 256'd1);
      check("awready_hold", {255'd0, s_axi_awready}, 256'd0);
      @(negedge clk);
    end
    s_axi_bready = 1;
    wait_drain();
    model[2] = 32'h0022_0044;
    check("reg_out_reg2", {'0, reg_out}, {'0, model_flat()});
    do_read(32'h8, 32'h0022_0044, 2'b00);
    wait_drain();

    // Read of reg1 handshaking on the commit edge returns the old value
    do_write(32'h4, 32'hCAFE_F00D, 4'hF, 0, 0, 2'b00);
    do_read(32'h4, 32'hDEAD_BEEF, 2'b00);
    wait_drain();
    model[1] = 32'hCAFE_F00D;
    do_read(32'h4, 32'hCAFE_F00D, 2'b00);
    wait_drain();

    // Reset while a read response is stalled
    s_axi_rready = 0;
    check("pre_ar_ready", {255'd0, s_axi_arready}, 256'd1);
    s_axi_araddr = 32'h4;
    s_axi_arvalid = 1;
    @(negedge clk);
    s_axi_arvalid = 0;
    check("stall_rvalid", {255'd0, s_axi_rvalid}, 256'd1);
    @(negedge clk);
    check("stall_rdata", {224'd0, s_axi_rdata}, 256'hCAFE_F00D);
    rstn = 0;
    @(negedge clk);
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    check("midrst_rvalid", {255'd0, s_axi_rvalid}, 256'd0);
    check("midrst_rdata", {224'd0, s_axi_rdata}, 256'd0);
    check("midrst_reg_out", {'0, reg_out}, {'0, model_flat()});
    s_axi_rready = 1;
    rstn = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_rvalid", {255'd0, s_axi_rvalid}, 256'd0);
    end
    do_read(32'h4, 32'h0, 2'b00);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
